// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
//   fetch_entry_t : one queue slot {pc, instr, filled} at the default widths
//   PC_STEP       : byte distance between sequential fetch addresses
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ILEN_DEFAULT = 32;
  localparam int unsigned PC_STEP      = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] instr;
    logic                    filled;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_unit_if.sv
// Instruction-memory request/grant bus plus the decode valid/ready bus.
//   master : prefetch unit side (drives imem_req/addr and instr_*)
//   slave  : memory + decode side
interface prefetch_unit_if #(
  parameter int unsigned XLEN = fetch_pkg::XLEN_DEFAULT,
  parameter int unsigned ILEN = fetch_pkg::ILEN_DEFAULT
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_slot_queue.sv
// DEPTH-slot in-order queue: slots are allocated on grant, filled in order
// by responses, freed from the head, and flushed on redirect.
//   alloc_en/alloc_pc : allocate the next slot for a granted request
//   fill_en/fill_data : write the oldest unfilled slot
//   free_en           : release the head slot
//   count/pend        : slots allocated / allocated-but-unfilled
//   head_*            : contents of the head slot
module fetch_slot_queue #(
  parameter int unsigned XLEN  = fetch_pkg::XLEN_DEFAULT,
  parameter int unsigned ILEN  = fetch_pkg::ILEN_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         alloc_en,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic                         fill_en,
  input  logic [ILEN-1:0]              fill_data,
  input  logic                         free_en,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   pend,
  output logic [XLEN-1:0]              head_pc,
  output logic [ILEN-1:0]              head_instr,
  output logic                         head_filled
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [ILEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head_ptr, alloc_ptr, fill_ptr;

  assign head_pc     = pc_q[head_ptr];
  assign head_instr  = instr_q[head_ptr];
  assign head_filled = filled_q[head_ptr];

  // Slot storage and pointers; alloc and fill never target the same slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q  <= '0;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
    end else if (flush) begin
      filled_q  <= '0;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
    end else begin
      if (alloc_en) begin
        pc_q[alloc_ptr]     <= alloc_pc;
        filled_q[alloc_ptr] <= 1'b0;
        alloc_ptr           <= alloc_ptr + PW'(1);
      end
      if (fill_en) begin
        instr_q[fill_ptr]  <= fill_data;
        // A head slot consumed straight from the response is never marked filled.
        filled_q[fill_ptr] <= !(free_en && (fill_ptr == head_ptr));
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (free_en) begin
        head_ptr <= head_ptr + PW'(1);
      end
      count <= count + CW'(alloc_en) - CW'(free_en);
      pend  <= pend + CW'(alloc_en) - CW'(fill_en);
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: owns the fetch PC, keeps up to DEPTH requests
// in flight, buffers responses in order and hands them to decode.
//   clk, reset_n          : clock, async active-low reset
//   redirect_valid/_pc    : one-cycle redirect to a new fetch address
//   bus (master)          : imem request/grant/response + decode valid/ready
// Optional build macro FETCH_BYPASS_EN: a response filling an empty head slot
// is presented to decode combinationally in the same cycle.
module prefetch_unit import fetch_pkg::*; #(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     ILEN     = ILEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  prefetch_unit_if.master bus
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc, redirect_aligned, head_pc;
  logic [ILEN-1:0] head_instr;
  logic [CW-1:0]   discard_cnt, q_count, q_pend;
  logic [CW:0]     credit_used;
  logic            grant, fill_en, drop_rsp, deq, head_alloc, head_filled;

  // Stale in-flight responses still hold credit until they return.
  assign credit_used  = {1'b0, q_count} + {1'b0, discard_cnt};
  assign bus.imem_req = reset_n && !redirect_valid && (credit_used < DEPTH_W);
  assign bus.imem_addr = fetch_pc;

  assign grant    = bus.imem_req && bus.imem_gnt;
  assign fill_en  = bus.imem_rvalid && !redirect_valid && (discard_cnt == '0);
  assign drop_rsp = bus.imem_rvalid && !redirect_valid && (discard_cnt != '0);
  assign head_alloc = (q_count != '0);
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass          = fill_en && head_alloc && !head_filled;
  assign bus.instr_valid = !redirect_valid && head_alloc && (head_filled || bypass);
  assign bus.instr       = bypass ? bus.imem_rdata : head_instr;
`else
  assign bus.instr_valid = !redirect_valid && head_alloc && head_filled;
  assign bus.instr       = head_instr;
`endif
  assign bus.instr_pc = head_pc;
  assign deq          = bus.instr_valid && bus.instr_ready;

  // Fetch PC and count of responses to discard after a redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_aligned;
      discard_cnt <= discard_cnt + q_pend - CW'(bus.imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
      if (drop_rsp) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  fetch_slot_queue #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (redirect_valid),
    .alloc_en    (grant),
    .alloc_pc    (fetch_pc),
    .fill_en     (fill_en),
    .fill_data   (bus.imem_rdata),
    .free_en     (deq),
    .count       (q_count),
    .pend        (q_pend),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .head_filled (head_filled)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// Randomized bench for prefetch_unit: an in-order memory model with random
// grant and latency, random decode back-pressure and redirects, checked each
// cycle against a queue-based reference of the fetch rules.
module tb_prefetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  prefetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  prefetch_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference state: allocated slots in order, fetch PC, stale responses owed.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  int           m_discard;

  // Memory model: granted addresses with the cycle their response is due.
  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  mem_req_t memq[$];
  int cyc = 0;
  int gnt_pct, ready_pct, lat_min, lat_max, redir_pct;
  int n_deq;
  bit last_rd = 1'b0;

  task automatic model_reset();
    mq.delete();
    memq.delete();
    m_pc      = RESET_PC;
    m_discard = 0;
  endtask

  task automatic check_reset_outputs(input string ph);
    check_eq({ph, ".rst_req"},   64'(bus.imem_req),    64'd0);
    check_eq({ph, ".rst_addr"},  64'(bus.imem_addr),   64'(RESET_PC));
    check_eq({ph, ".rst_valid"}, 64'(bus.instr_valid), 64'd0);
    check_eq({ph, ".rst_instr"}, 64'(bus.instr),       64'd0);
    check_eq({ph, ".rst_pc"},    64'(bus.instr_pc),    64'd0);
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit rd, input logic [31:0] rpc, input string ph);
    bit          gnt, rdy, rv, exp_req, exp_valid, byp_hit, deq, found;
    logic [31:0] rdata, exp_instr;
    int          unf;
    rv    = (memq.size() > 0) && (memq[0].due <= cyc);
    gnt   = ($urandom % 100) < gnt_pct;
    rdy   = ($urandom % 100) < ready_pct;
    rdata = $urandom;
    redirect_valid  = rd;
    redirect_pc     = rpc;
    bus.imem_gnt    = gnt;
    bus.instr_ready = rdy;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdata;
    #1;
    exp_req   = !rd && (mq.size() + m_discard < DEPTH);
    byp_hit   = BYPASS && rv && (m_discard == 0) && (mq.size() > 0) && !mq[0].filled;
    exp_valid = !rd && (mq.size() > 0) && (mq[0].filled || byp_hit);
    check_eq({ph, ".req"},   64'(bus.imem_req),    64'(exp_req));
    check_eq({ph, ".addr"},  64'(bus.imem_addr),   64'(m_pc));
    check_eq({ph, ".valid"}, 64'(bus.instr_valid), 64'(exp_valid));
    if (exp_valid) begin
      exp_instr = mq[0].filled ? mq[0].instr : rdata;
      check_eq({ph, ".instr"},    64'(bus.instr),    64'(exp_instr));
      check_eq({ph, ".instr_pc"}, 64'(bus.instr_pc), 64'(mq[0].pc));
    end
    if (bus.instr_valid && rdy) n_deq++;
    // Memory reacts to what the DUT actually did.
    if (bus.imem_req && gnt)
      memq.push_back('{addr: bus.imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
    if (rv) void'(memq.pop_front());
    // Advance the reference.
    if (rd) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      m_discard = m_discard + unf - int'(rv);
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      deq = exp_valid && rdy;
      if (rv) begin
        if (m_discard > 0) m_discard--;
        else begin
          found = 1'b0;
          foreach (mq[i]) if (!found && !mq[i].filled) begin
            mq[i].filled = 1'b1;
            mq[i].instr  = rdata;
            found = 1'b1;
          end
        end
      end
      if (deq) void'(mq.pop_front());
      if (exp_req && gnt) begin
        mq.push_back('{pc: m_pc, instr: '0, filled: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    last_rd = rd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input string ph);
    bit rd;
    for (int i = 0; i < n; i++) begin
      rd = !last_rd && (($urandom % 100) < redir_pct);
      step(rd, $urandom, ph);
    end
  endtask

  task automatic knobs(input int g, input int r, input int lmin, input int lmax, input int rdp);
    gnt_pct = g; ready_pct = r; lat_min = lmin; lat_max = lmax; redir_pct = rdp;
  endtask

  initial begin
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Zero-wait memory, decode always ready: one instruction per cycle.
    knobs(100, 100, 1, 1, 0);
    run(4, "stream_warm");
    n_deq = 0;
    run(16, "stream");
    check_eq("throughput", 64'(n_deq), 64'd16);

    // Decode stalled: DEPTH grants then request drops; then drain.
    knobs(100, 0, 1, 1, 0);
    run(8, "stall");
    knobs(100, 100, 1, 1, 0);
    run(8, "drain");

    // Three in flight at k=3, redirect coincides with a response and a dequeue.
    redirect_valid = 1'b0;
    step(1'b1, 32'h0000_0000, "resync");
    knobs(100, 100, 3, 3, 0);
    run(5, "k3_fill");
    step(1'b1, 32'h0000_2002, "k3_redir");
    run(14, "k3_after");

    // Fetch PC wraps past the top of the address space.
    knobs(100, 100, 1, 1, 0);
    step(1'b1, 32'hFFFF_FFFC, "wrap_redir");
    run(8, "wrap");

    // Random traffic with back-pressure, latency and redirects.
    knobs(70, 60, 1, 4, 3);
    run(3000, "rand");

    // Reset in the middle of traffic.
    reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    bus.imem_rvalid = 1'b0;
    last_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    knobs(80, 70, 1, 2, 2);
    run(200, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction prefetch unit that succeeds the single-request fetch stage. It owns the fetch PC and issues sequential requests to instruction memory over a request/grant handshake, keeping several requests in flight. Returned instructions are buffered with their PCs in a DEPTH-entry in-order queue and handed to decode over a valid/ready interface. A redirect flushes the queue and silently drops responses still in flight.

## Interface
- XLEN, 32: PC/address width.
- ILEN, 32: instruction width.
- DEPTH, 4: queue slots; power of two, ≥2; also the cap on requests in flight.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  branch/exception redirect, one-cycle pulse.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored and treated as 0.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after their grant.
- imem_rdata  in  ILEN  response data.
- instr_valid  out  1  head instruction available.
- instr  out  ILEN  head instruction.
- instr_pc  out  XLEN  PC of the head instruction.
- instr_ready  in  1  decode accepts the head.

## Operation
- State:
  - fetch_pc, reset to RESET_PC.
  - Circular queue of DEPTH slots, each holding {pc, instr, filled}.
  - Pointers: head, alloc, fill.
  - count: slots allocated.
  - discard_cnt: stale responses still to drop.
- imem_req = reset_n && !redirect_valid && (count + discard_cnt < DEPTH); imem_addr = fetch_pc.
- Grant (imem_req && imem_gnt):
  - Allocate the slot at alloc with pc = fetch_pc, filled = 0.
  - Advance alloc; fetch_pc += 4, wrapping modulo 2^XLEN.
- Response:
  - If discard_cnt > 0: decrement it and drop the data.
  - Otherwise: write imem_rdata into the slot at fill, set filled, advance fill.
- Dequeue: instr_valid = head slot allocated && filled. On instr_valid && instr_ready, free the head slot and advance head.
- Redirect, which has priority over everything else in its cycle:
  - Flush all slots; head = alloc = fill = 0; count = 0.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - discard_cnt_next = discard_cnt + (allocated-but-unfilled slots) − imem_rvalid.
  - Any same-cycle response is dropped.
  - imem_req = 0 and instr_valid = 0 in the redirect cycle, so no grant or dequeue can occur.
- Simultaneous grant, response and dequeue in one cycle are all legal; count_next = count + grant − dequeue.
- Full: count + discard_cnt == DEPTH deasserts imem_req. imem_req does not wait on instr_ready.
- Empty: instr_valid = 0. instr and instr_pc hold the last head contents; their values are don't-care when invalid.

## Timing
- Reset values: imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0.
- imem_req rises in the first clock cycle after reset_n deasserts.
- Reset asserted mid-operation clears all state immediately. Responses outstanding at reset are the memory's responsibility and must not arrive afterwards.
- A granted request at cycle T with response at T+k gives instr_valid at T+k+1 (bypass off).
- With a zero-wait memory (k=1) and instr_ready held high, sustained throughput is 1 instruction per cycle once DEPTH ≥ 2.
- After a redirect at cycle R, the first request to the new PC is issued at R+1, provided in-flight credit allows.

## Configuration
- FETCH_BYPASS_EN defined:
  - A response filling the head slot while that slot is unfilled drives instr_valid, instr and instr_pc combinationally in the same cycle, so latency becomes T+k.
  - If instr_ready is also high, the slot is freed without ever being marked filled.
  - A redirect in that cycle still suppresses instr_valid.
- FETCH_BYPASS_EN undefined: responses are always registered first. There is no combinational path from imem_* to instr_*.

## Structure
- fetch_pkg holds:
  - fetch_entry_t {pc, instr, filled}.
  - PC_STEP = 4.
  - Default ILEN and XLEN.
- One sub-module is natural: fetch_slot_queue, the DEPTH-slot allocate/fill/free queue with flush. The top level holds fetch_pc, discard_cnt and the request logic.

## Test plan
- Reset release, RESET_PC=0x100, memory gnt=1, k=1, instr_ready=1: addresses 0x100, 0x104, 0x108 issue on consecutive cycles, and instr_pc sequence 0x100, 0x104, … appears one instruction per cycle.
- instr_ready=0, DEPTH=4: exactly 4 grants, then imem_req=0. Raise instr_ready and the queue drains in order, with imem_req re-asserting the cycle after the first dequeue.
- Three requests in flight (k=3) when a redirect to 0x2002 arrives: all three responses are dropped; the first delivered instruction has instr_pc=0x2000.
- Redirect in the same cycle as imem_rvalid and instr_valid&&instr_ready: no dequeue, the response is dropped, and discard_cnt equals pending−1.
- fetch_pc=0xFFFF_FFFC, XLEN=32: the next request address wraps to 0x0000_0000.
- FETCH_BYPASS_EN defined, empty queue, k=1: instr_valid is high in the same cycle as imem_rvalid with matching instr; with the macro undefined it is high one cycle later.
